// File: rtl/cdc_hs_rx_if.sv
// rtl/cdc_hs_rx_if.sv - downstream valid/ready word interface of the toggle-handshake receiver
interface cdc_hs_rx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;

  modport master (output data_out, output out_valid, input out_ready);
  modport slave  (input data_out, input out_valid, output out_ready);
endinterface

// File: rtl/cdc_hs_rx.sv
// rtl/cdc_hs_rx.sv - receive side of a two-phase req/ack toggle CDC handshake
// Synchronizes req_tgl, captures the sender-held word, presents it valid/ready, acks on accept.
module cdc_hs_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_tgl,
  input  logic [WIDTH-1:0] data_in,
  output logic             ack_tgl,
  output logic             err,
  input  logic             err_clr,
  output logic [7:0]       word_cnt,
  cdc_hs_rx_if.master      dout
);

  typedef enum logic [1:0] {PRIME, IDLE, HOLD} state_t;

  localparam logic [2:0] PRIME_LAST = 3'(SYNC_STAGES);

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;
  logic                   req_prev;
  logic                   req_edge;
  logic [2:0]             prime_cnt;
  logic                   prime_last;
  logic                   capture;
  logic                   accept;
  logic                   err_set;

  assign sync_out = sync[SYNC_STAGES-1];
  assign req_edge = sync_out ^ req_prev;

  // req_prev follows the synchronizer in every state so a discarded edge is not seen twice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= '0;
      req_prev <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], req_tgl};
      req_prev <= sync_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PRIME;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PRIME:   if (prime_last) state_nxt = IDLE;
      IDLE:    if (req_edge)   state_nxt = HOLD;
      HOLD:    if (accept)     state_nxt = IDLE;
      default: state_nxt = PRIME;
    endcase
  end

  always_comb begin
    prime_last = 1'b0;
    capture    = 1'b0;
    accept     = 1'b0;
    err_set    = 1'b0;
    case (state)
      PRIME: prime_last = (prime_cnt == PRIME_LAST);
      IDLE:  capture    = req_edge;
      HOLD: begin
        accept  = dout.out_valid & dout.out_ready;
        err_set = req_edge;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime_cnt <= '0;
    end else if (state == PRIME) begin
      prime_cnt <= prime_cnt + 3'd1;
    end
  end

  // Priming ack to the settled req level leaves the link idle whatever the sender holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_tgl <= 1'b0;
    end else if (prime_last) begin
      ack_tgl <= sync_out;
    end else if (accept) begin
      ack_tgl <= ~ack_tgl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout.data_out  <= '0;
      dout.out_valid <= 1'b0;
      word_cnt       <= '0;
    end else begin
      if (capture) begin
        dout.data_out  <= data_in;
        dout.out_valid <= 1'b1;
      end else if (accept) begin
        dout.out_valid <= 1'b0;
      end
      if (accept) begin
        word_cnt <= word_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule
